pmem_arbiter_rr: RTL and testbench
==================================

Name: pmem_arbiter_rr

Overview:
- Parametrised N-port arbiter between cache-line requesters (I-cache, D-cache, future L2/prefetch/DMA ports) and a single physical memory port.
- Successor to the fixed two-port I/D arbiter. Generalised in port count, address width and block width.
- Adds selectable fixed-priority or round-robin arbitration, registered request capture, and a per-port one-cycle response pulse.
- Sits between the cache instances and the top-level pmem_* pins.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- ADDR_W, 16, physical address width in bits.
- BLOCK_W, 128, cache-line width in bits.
- RR_MODE, 1: round-robin arbitration. 0: fixed priority, port 0 highest.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_PORTS  per-port line-read request, level.
- req_write  in  NUM_PORTS  per-port line-write request, level.
- req_address  in  NUM_PORTS*ADDR_W  per-port address. Port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*BLOCK_W  per-port write line, sliced the same way.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port.
- req_rdata  out  BLOCK_W  read line, broadcast to all ports; valid when req_resp is high.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_address  out  ADDR_W  physical address.
- pmem_wdata  out  BLOCK_W  physical write line.
- pmem_rdata  in  BLOCK_W  physical read line.
- pmem_resp  in  1  physical completion, one cycle.
- busy  out  1  high whenever state != IDLE. The pipeline uses it to freeze inter-stage registers.
- grant_id  out  $clog2(NUM_PORTS)  index of the port currently or last granted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_resp=0; req_rdata=0.
  - pmem_read=0, pmem_write=0; pmem_address=0, pmem_wdata=0.
  - busy=0; grant_id=0; round-robin pointer=0.
- Reset asserted mid-transaction aborts it immediately. The pmem strobes drop asynchronously; any later pmem_resp is ignored.
- A port is pending when req_read[i] | req_write[i].
- If a port asserts both, the write is serviced first. The read stays pending and is arbitrated again later.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any port is pending, select a winner and latch its index, op, address and wdata into registers.
  - Move to ACCESS the next cycle.
  - With no pending port, stay in IDLE with all outputs quiet.
- Arbitration:
  - RR_MODE=1: first pending port searching from the pointer upward, with wrap-around modulo NUM_PORTS. On grant, pointer = winner+1, wrapping from NUM_PORTS-1 to 0.
  - RR_MODE=0: lowest-index pending port wins; the pointer is unused.
- ACCESS:
  - pmem_read or pmem_write is driven from the latched op. pmem_address and pmem_wdata come from the latches and are stable for the whole access.
  - Requester inputs are ignored. Dropping a request mid-access does not cancel it.
  - On pmem_resp: capture pmem_rdata into req_rdata, deassert the strobes in the next cycle, and go to DONE.
- DONE:
  - req_resp[grant] = 1 for exactly this cycle; pmem strobes are 0.
  - The requester must drop or change its request in this cycle.
  - Return to IDLE. New arbitration happens in IDLE only, so there is a minimum 1-cycle gap between transactions.
- Latency:
  - Request seen in IDLE at cycle t puts the strobe high at t+1.
  - pmem_resp at cycle r gives req_resp at r+1.
- req_rdata holds its last captured value until the next read completes. Writes do not update it.
- pmem_resp arriving in IDLE or DONE is ignored.
- busy is high in ACCESS and DONE. It is registered (not combinational on requests).

Optional Feature:
- Macro PMEM_ARB_PERF_EN.
- When defined:
  - Adds output perf_grants (NUM_PORTS*16): one 16-bit grant counter per port, incremented on entry to ACCESS, saturating at 16'hFFFF.
  - Adds output perf_wait (NUM_PORTS*16): one 16-bit counter per port, incremented every cycle that port is pending but not granted, saturating.
  - All counters clear on rst_n.
- When undefined: these ports and their logic do not exist; the rest of the behaviour is identical.

Test Plan:
- NUM_PORTS=2: port0 read 16'h1230 alone; pmem_resp 3 cycles after the strobe with rdata=128'hA5..A5 -> pmem_read high from t+1, address 16'h1230, req_resp[0] pulse 1 cycle after pmem_resp, req_rdata=A5..A5, busy high through DONE.
- RR_MODE=1, NUM_PORTS=4: all ports hold read requests continuously -> grant order 0,1,2,3,0 with each req_resp one-hot in sequence. RR_MODE=0 with the same stimulus -> port 0 granted every transaction.
- Port1 asserts read and write at 16'h0040 with wdata=128'h1 -> write serviced first (pmem_write, wdata=1), then the read issued in a separate transaction.
- Port0 drops req_read 1 cycle into ACCESS -> access completes, req_resp[0] still pulses, pmem_address unchanged throughout.
- rst_n low for 1 cycle during ACCESS -> pmem_read falls without waiting for a clock edge, state IDLE, pointer 0; a late pmem_resp produces no req_resp.
- With PMEM_ARB_PERF_EN, port0 granted 3 times while port1 waits 5 cycles -> perf_grants[0]=3, perf_wait[1]=5.

Source files
------------

// File: rtl/pmem_arbiter_rr_if.sv
// Bus bundle between pmem_arbiter_rr, its cache-line requesters and the physical memory port.
// master is the arbiter's view; slave is the requesters plus memory as seen from outside.
interface pmem_arbiter_rr_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BLOCK_W   = 128
);
    logic [NUM_PORTS-1:0]         req_read;
    logic [NUM_PORTS-1:0]         req_write;
    logic [NUM_PORTS*ADDR_W-1:0]  req_address;
    logic [NUM_PORTS*BLOCK_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]         req_resp;
    logic [BLOCK_W-1:0]           req_rdata;

    logic                         pmem_read;
    logic                         pmem_write;
    logic [ADDR_W-1:0]            pmem_address;
    logic [BLOCK_W-1:0]           pmem_wdata;
    logic [BLOCK_W-1:0]           pmem_rdata;
    logic                         pmem_resp;

    modport master (
        input  req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
        output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
        input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter_rr.sv
// N-port cache-line arbiter onto a single physical memory port, round-robin or fixed priority.
// Optional per-port grant/wait counters are built when PMEM_ARB_PERF_EN is defined.
module pmem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BLOCK_W   = 128,
    parameter int RR_MODE   = 1,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pmem_arbiter_rr_if.master bus,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id
`ifdef PMEM_ARB_PERF_EN
    ,
    output logic [NUM_PORTS*16-1:0] perf_grants,
    output logic [NUM_PORTS*16-1:0] perf_wait
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                op_write_q, op_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLOCK_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0]  rdata_q, rdata_d;
    logic                busy_q, busy_d;

    logic [NUM_PORTS-1:0] pending;
    logic [IDX_W-1:0]     base_ptr;
    logic [IDX_W-1:0]     cand_idx [NUM_PORTS];
    logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
    logic [BLOCK_W-1:0]   wdata_arr [NUM_PORTS];
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 grant_now;

    assign pending   = bus.req_read | bus.req_write;
    assign base_ptr  = (RR_MODE != 0) ? rr_ptr_q : '0;
    assign grant_now = (state_q == IDLE) && win_found;

    // Candidate k is the port examined k-th, starting at the pointer and wrapping modulo NUM_PORTS.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum           = {1'b0, base_ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi]  = (sum >= (IDX_W+1)'(NUM_PORTS))
                             ? IDX_W'(sum - (IDX_W+1)'(NUM_PORTS))
                             : sum[IDX_W-1:0];
        assign addr_arr[gi]  = bus.req_address[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = bus.req_wdata[gi*BLOCK_W +: BLOCK_W];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (pending[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ACCESS;
            ACCESS:  if (bus.pmem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture; a port asking for both read and write gets its write first.
    always_comb begin
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if (grant_now) begin
            grant_d    = win_idx;
            op_write_d = bus.req_write[win_idx];
            addr_d     = addr_arr[win_idx];
            wdata_d    = wdata_arr[win_idx];
            if (RR_MODE != 0) begin
                rr_ptr_d = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
            end
        end
        if ((state_q == ACCESS) && bus.pmem_resp && !op_write_q) begin
            rdata_d = bus.pmem_rdata;
        end
        busy_d = (state_d != IDLE);
    end

    // Outputs decode straight from registers so reset drops the strobes without a clock.
    always_comb begin
        bus.pmem_read    = (state_q == ACCESS) && !op_write_q;
        bus.pmem_write   = (state_q == ACCESS) && op_write_q;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q;
        bus.req_rdata    = rdata_q;
        bus.req_resp     = '0;
        if (state_q == DONE) begin
            bus.req_resp[grant_q] = 1'b1;
        end
        busy     = busy_q;
        grant_id = grant_q;
    end

`ifdef PMEM_ARB_PERF_EN
    // The granted port counts as served from its IDLE win through DONE, so it never accrues wait.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_perf
        logic [15:0] grants_q, grants_d;
        logic [15:0] wait_q, wait_d;
        logic        won_now;
        logic        served;

        always_comb begin
            won_now  = grant_now && (win_idx == IDX_W'(gi));
            served   = (state_q != IDLE) && (grant_q == IDX_W'(gi));
            grants_d = grants_q;
            wait_d   = wait_q;
            if (won_now && (grants_q != 16'hFFFF)) begin
                grants_d = grants_q + 16'd1;
            end
            if (pending[gi] && !won_now && !served && (wait_q != 16'hFFFF)) begin
                wait_d = wait_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grants_q <= '0;
                wait_q   <= '0;
            end else begin
                grants_q <= grants_d;
                wait_q   <= wait_d;
            end
        end

        assign perf_grants[gi*16 +: 16] = grants_q;
        assign perf_wait[gi*16 +: 16]   = wait_q;
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Directed self-checking bench for pmem_arbiter_rr: a 2-port round-robin instance plus
// 4-port round-robin and fixed-priority instances driven in lockstep.
`timescale 1ns/1ps
module tb_pmem_arbiter_rr;
    localparam int AW = 16;
    localparam int BW = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pmem_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_W(AW), .BLOCK_W(BW)) a_if ();
    pmem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW)) b_if ();
    pmem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW)) c_if ();

    logic       a_busy, b_busy, c_busy;
    logic [0:0] a_gid;
    logic [1:0] b_gid, c_gid;
`ifdef PMEM_ARB_PERF_EN
    logic [31:0] a_pg, a_pw;
    logic [63:0] b_pg, b_pw, c_pg, c_pw;
`endif

    pmem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .busy(a_busy), .grant_id(a_gid)
`ifdef PMEM_ARB_PERF_EN
        , .perf_grants(a_pg), .perf_wait(a_pw)
`endif
    );

    pmem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .busy(b_busy), .grant_id(b_gid)
`ifdef PMEM_ARB_PERF_EN
        , .perf_grants(b_pg), .perf_wait(b_pw)
`endif
    );

    pmem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if), .busy(c_busy), .grant_id(c_gid)
`ifdef PMEM_ARB_PERF_EN
        , .perf_grants(c_pg), .perf_wait(c_pw)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_if.pmem_read, a_if.pmem_write, a_if.req_resp, a_busy, a_gid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b, expected 000000",
                     {a_if.pmem_read, a_if.pmem_write, a_if.req_resp, a_busy, a_gid});
        end
        checks++;
        if ({a_if.pmem_address, a_if.pmem_wdata, a_if.req_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data_a: addr=%h wdata=%h rdata=%h, expected all zero",
                     a_if.pmem_address, a_if.pmem_wdata, a_if.req_rdata);
        end
        checks++;
        if ({b_if.pmem_read, b_if.req_resp, b_busy, b_gid, c_if.pmem_read, c_if.req_resp, c_busy, c_gid} !== 16'b0) begin
            errors++;
            $display("FAIL reset_ctrl_bc: got %b, expected all zero",
                     {b_if.pmem_read, b_if.req_resp, b_busy, b_gid, c_if.pmem_read, c_if.req_resp, c_busy, c_gid});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_single_read();
        logic [BW-1:0] a5;
        a5 = {16{8'hA5}};
        a_if.req_address[0 +: AW] = 16'h1230;
        a_if.req_read[0] = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (a_if.pmem_read !== 1'b1 || a_if.pmem_write !== 1'b0) begin
                errors++;
                $display("FAIL single_strobe cyc%0d: read=%b write=%b, expected read=1 write=0",
                         c, a_if.pmem_read, a_if.pmem_write);
            end
            checks++;
            if (a_if.pmem_address !== 16'h1230 || a_busy !== 1'b1 || a_if.req_resp !== 2'b00) begin
                errors++;
                $display("FAIL single_access cyc%0d: addr=%h busy=%b resp=%b, expected 1230 1 00",
                         c, a_if.pmem_address, a_busy, a_if.req_resp);
            end
            tick();
        end
        a_if.pmem_rdata = a5;
        a_if.pmem_resp  = 1'b1;
        tick();
        checks++;
        if (a_if.req_resp !== 2'b01 || a_if.pmem_read !== 1'b0 || a_busy !== 1'b1 || a_gid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: resp=%b read=%b busy=%b gid=%0d, expected 01 0 1 0",
                     a_if.req_resp, a_if.pmem_read, a_busy, a_gid);
        end
        checks++;
        if (a_if.req_rdata !== a5) begin
            errors++;
            $display("FAIL single_rdata: got %h, expected %h", a_if.req_rdata, a5);
        end
        a_if.req_read[0] = 1'b0;
        a_if.pmem_resp   = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_if.req_resp !== 2'b00 || a_if.req_rdata !== a5) begin
            errors++;
            $display("FAIL single_idle: busy=%b resp=%b rdata=%h, expected 0 00 %h",
                     a_busy, a_if.req_resp, a_if.req_rdata, a5);
        end
        $display("txn single read port0 addr 1230 done");
    endtask

    task automatic test_rr_vs_fixed();
        logic [1:0]  exp_id;
        logic [3:0]  exp_oh;
        logic [15:0] exp_addr;
        for (int p = 0; p < 4; p++) begin
            b_if.req_address[p*AW +: AW] = 16'(16'h0100 * (p + 1));
            c_if.req_address[p*AW +: AW] = 16'(16'h0100 * (p + 1));
        end
        b_if.req_read = 4'hF;
        c_if.req_read = 4'hF;
        for (int t = 0; t < 5; t++) begin
            exp_id   = 2'(t % 4);
            exp_oh   = 4'b0001 << exp_id;
            exp_addr = 16'(16'h0100 * (exp_id + 1));
            tick();
            checks++;
            if (b_gid !== exp_id || b_if.pmem_address !== exp_addr || b_if.pmem_read !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant t%0d: gid=%0d addr=%h read=%b, expected %0d %h 1",
                         t, b_gid, b_if.pmem_address, b_if.pmem_read, exp_id, exp_addr);
            end
            checks++;
            if (c_gid !== 2'd0 || c_if.pmem_address !== 16'h0100 || c_if.pmem_read !== 1'b1) begin
                errors++;
                $display("FAIL fixed_grant t%0d: gid=%0d addr=%h read=%b, expected 0 0100 1",
                         t, c_gid, c_if.pmem_address, c_if.pmem_read);
            end
            b_if.pmem_resp = 1'b1;
            c_if.pmem_resp = 1'b1;
            tick();
            checks++;
            if (b_if.req_resp !== exp_oh || c_if.req_resp !== 4'b0001) begin
                errors++;
                $display("FAIL rr_fixed_resp t%0d: rr=%b fixed=%b, expected %b 0001",
                         t, b_if.req_resp, c_if.req_resp, exp_oh);
            end
            b_if.pmem_resp = 1'b0;
            c_if.pmem_resp = 1'b0;
            tick();
            $display("txn rr port%0d / fixed port0 completed", exp_id);
        end
        b_if.req_read = 4'h0;
        c_if.req_read = 4'h0;
        tick();
    endtask

    task automatic test_write_first();
        logic [BW-1:0] a5;
        logic [BW-1:0] v5a;
        logic [BW-1:0] one;
        a5  = {16{8'hA5}};
        v5a = {16{8'h5A}};
        one = 128'h1;
        a_if.req_address[AW +: AW] = 16'h0040;
        a_if.req_wdata[BW +: BW]   = one;
        a_if.req_read[1]  = 1'b1;
        a_if.req_write[1] = 1'b1;
        tick();
        checks++;
        if (a_if.pmem_write !== 1'b1 || a_if.pmem_read !== 1'b0 || a_gid !== 1'b1) begin
            errors++;
            $display("FAIL wr_first_strobe: write=%b read=%b gid=%0d, expected 1 0 1",
                     a_if.pmem_write, a_if.pmem_read, a_gid);
        end
        checks++;
        if (a_if.pmem_address !== 16'h0040 || a_if.pmem_wdata !== one) begin
            errors++;
            $display("FAIL wr_first_data: addr=%h wdata=%h, expected 0040 %h",
                     a_if.pmem_address, a_if.pmem_wdata, one);
        end
        a_if.pmem_rdata = {16{8'hC3}};
        a_if.pmem_resp  = 1'b1;
        tick();
        checks++;
        if (a_if.req_resp !== 2'b10 || a_if.req_rdata !== a5) begin
            errors++;
            $display("FAIL wr_done: resp=%b rdata=%h, expected 10 %h", a_if.req_resp, a_if.req_rdata, a5);
        end
        $display("txn write port1 addr 0040 done");
        a_if.req_write[1] = 1'b0;
        a_if.pmem_resp    = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_if.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL wr_gap: busy=%b read=%b, expected 0 0", a_busy, a_if.pmem_read);
        end
        tick();
        checks++;
        if (a_if.pmem_read !== 1'b1 || a_if.pmem_write !== 1'b0 || a_gid !== 1'b1 || a_if.pmem_address !== 16'h0040) begin
            errors++;
            $display("FAIL rd_after_wr: read=%b write=%b gid=%0d addr=%h, expected 1 0 1 0040",
                     a_if.pmem_read, a_if.pmem_write, a_gid, a_if.pmem_address);
        end
        a_if.pmem_rdata = v5a;
        a_if.pmem_resp  = 1'b1;
        tick();
        checks++;
        if (a_if.req_resp !== 2'b10 || a_if.req_rdata !== v5a) begin
            errors++;
            $display("FAIL rd_after_wr_done: resp=%b rdata=%h, expected 10 %h", a_if.req_resp, a_if.req_rdata, v5a);
        end
        $display("txn read port1 addr 0040 done");
        a_if.req_read[1] = 1'b0;
        a_if.pmem_resp   = 1'b0;
        tick();
    endtask

    task automatic test_drop_mid_access();
        logic [BW-1:0] v7e;
        v7e = {16{8'h7E}};
        a_if.req_address[0 +: AW] = 16'h2220;
        a_if.req_read[0] = 1'b1;
        tick();
        tick();
        a_if.req_read[0] = 1'b0;
        a_if.req_address[0 +: AW] = 16'hFFFF;
        tick();
        checks++;
        if (a_if.pmem_read !== 1'b1 || a_if.pmem_address !== 16'h2220) begin
            errors++;
            $display("FAIL drop_access: read=%b addr=%h, expected 1 2220", a_if.pmem_read, a_if.pmem_address);
        end
        a_if.pmem_rdata = v7e;
        a_if.pmem_resp  = 1'b1;
        tick();
        checks++;
        if (a_if.req_resp !== 2'b01 || a_if.req_rdata !== v7e || a_if.pmem_address !== 16'h2220) begin
            errors++;
            $display("FAIL drop_done: resp=%b rdata=%h addr=%h, expected 01 %h 2220",
                     a_if.req_resp, a_if.req_rdata, a_if.pmem_address, v7e);
        end
        $display("txn dropped read port0 addr 2220 done");
        a_if.pmem_resp = 1'b0;
        tick();
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_if.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_retry: busy=%b read=%b, expected 0 0", a_busy, a_if.pmem_read);
        end
    endtask

    task automatic test_async_reset();
        a_if.req_address[0 +: AW] = 16'h3330;
        a_if.req_read[0] = 1'b1;
        tick();
        checks++;
        if (a_if.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: read=%b, expected 1", a_if.pmem_read);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_if.pmem_read !== 1'b0 || a_busy !== 1'b0 || a_if.pmem_address !== 16'h0000) begin
            errors++;
            $display("FAIL arst_async: read=%b busy=%b addr=%h, expected 0 0 0000",
                     a_if.pmem_read, a_busy, a_if.pmem_address);
        end
        a_if.req_read[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        a_if.pmem_resp = 1'b1;
        tick();
        checks++;
        if (a_if.req_resp !== 2'b00 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_late_resp: resp=%b busy=%b, expected 00 0", a_if.req_resp, a_busy);
        end
        a_if.pmem_resp = 1'b0;
        a_if.req_read  = 2'b11;
        tick();
        checks++;
        if (a_gid !== 1'b0 || a_if.pmem_address !== 16'h3330) begin
            errors++;
            $display("FAIL arst_ptr: gid=%0d addr=%h, expected 0 3330", a_gid, a_if.pmem_address);
        end
        a_if.pmem_resp = 1'b1;
        tick();
        a_if.req_read  = 2'b00;
        a_if.pmem_resp = 1'b0;
        tick();
        $display("txn reset abort and pointer restart done");
    endtask

`ifdef PMEM_ARB_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_if.req_address[0 +: AW] = 16'h0500;
        a_if.req_read[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (n == 2) a_if.req_read[1] = 1'b1;
            tick();
            tick();
            tick();
            a_if.pmem_resp = 1'b1;
            tick();
            a_if.pmem_resp = 1'b0;
            if (n == 2) a_if.req_read[0] = 1'b0;
            tick();
        end
        tick();
        checks++;
        if (a_pg[15:0] !== 16'd3 || a_pg[31:16] !== 16'd1) begin
            errors++;
            $display("FAIL perf_grants: p0=%0d p1=%0d, expected 3 1", a_pg[15:0], a_pg[31:16]);
        end
        checks++;
        if (a_pw[31:16] !== 16'd5 || a_pw[15:0] !== 16'd0 || a_gid !== 1'b1) begin
            errors++;
            $display("FAIL perf_wait: p1=%0d p0=%0d gid=%0d, expected 5 0 1", a_pw[31:16], a_pw[15:0], a_gid);
        end
        a_if.pmem_resp = 1'b1;
        tick();
        a_if.req_read[1] = 1'b0;
        a_if.pmem_resp   = 1'b0;
        tick();
        $display("txn perf counters sampled");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.req_read = '0; a_if.req_write = '0; a_if.req_address = '0; a_if.req_wdata = '0;
        a_if.pmem_rdata = '0; a_if.pmem_resp = 1'b0;
        b_if.req_read = '0; b_if.req_write = '0; b_if.req_address = '0; b_if.req_wdata = '0;
        b_if.pmem_rdata = '0; b_if.pmem_resp = 1'b0;
        c_if.req_read = '0; c_if.req_write = '0; c_if.req_address = '0; c_if.req_wdata = '0;
        c_if.pmem_rdata = '0; c_if.pmem_resp = 1'b0;

        test_reset();
        test_single_read();
        test_rr_vs_fixed();
        test_write_first();
        test_drop_mid_access();
        test_async_reset();
`ifdef PMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
